// File: rtl/ibex_rf_wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Index width and register count both follow RV32E.
package ibex_rf_wb_pkg;

  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [4:0]    waddr;
    logic [DW-1:0] wdata;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LSU
  } src_e;

  function automatic int unsigned addr_width(bit rv32e);
    return rv32e ? 4 : 5;
  endfunction

  function automatic int unsigned num_words(bit rv32e);
    return 32'd1 << addr_width(rv32e);
  endfunction

endpackage

// File: rtl/ibex_rf_wb_fifo.sv
// Small circular buffer for writeback requests.
// Push on a full buffer or pop on an empty one is ignored.
module ibex_rf_wb_fifo
  import ibex_rf_wb_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter type req_t = wb_req_t,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push,
  input  req_t            wdata,
  input  logic            pop,
  output req_t            rdata,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  req_t            mem [Depth];
  logic [PtrW-1:0] wptr;
  logic [PtrW-1:0] rptr;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= inc(wptr);
      if (do_pop)  rptr <= inc(rptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Register-file writeback arbiter with pending-load scoreboard.
// Define IBEX_RF_WB_FWD_EN to serve output-stage matches by forwarding.
module ibex_rf_wb_arbiter
  import ibex_rf_wb_pkg::*;
#(
  parameter bit          RV32E        = 1'b0,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned LsuFifoDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alu_valid_i,
  input  logic [4:0]           alu_waddr_i,
  input  logic [DataWidth-1:0] alu_wdata_i,
  output logic                 alu_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_ready_o,
  input  logic                 lsu_issue_i,
  input  logic [4:0]           lsu_issue_addr_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 fwd_a_o,
  output logic                 fwd_b_o,
  output logic [DataWidth-1:0] fwd_data_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 we_a_o,
  output logic                 err_o
);

  localparam int unsigned AW   = addr_width(RV32E);
  localparam int unsigned NW   = num_words(RV32E);
  localparam int unsigned CntW = $clog2(LsuFifoDepth + 1);

  typedef struct packed {
    logic [4:0]           waddr;
    logic [DataWidth-1:0] wdata;
  } req_t;

  req_t            sel_req;
  req_t            fifo_head;
  req_t            lsu_req;
  src_e            sel_src;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [NW-1:0]   pending;
  logic [NW-1:0]   set_vec;
  logic [NW-1:0]   clr_vec;
  logic [AW-1:0]   sel_idx;
  logic [AW-1:0]   iss_idx;
  logic            sel_ok;
  logic            iss_ok;
  logic            err_now;
  logic            pend_a;
  logic            pend_b;

  // x0 and, under RV32E, x16..x31 are not backed by storage
  function automatic logic in_rf(logic [4:0] a);
    return (a != 5'd0) && !(RV32E && a[4]);
  endfunction

  assign lsu_req     = '{waddr: lsu_waddr_i, wdata: lsu_wdata_i};
  assign lsu_ready_o = rst_ni && (fifo_count < CntW'(LsuFifoDepth));
  assign alu_ready_o = rst_ni && fifo_empty && !lsu_valid_i;
  assign fifo_push   = lsu_valid_i && lsu_ready_o && !fifo_empty;

  ibex_rf_wb_fifo #(
    .Depth (LsuFifoDepth),
    .req_t (req_t)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (fifo_push),
    .wdata  (lsu_req),
    .pop    (fifo_pop),
    .rdata  (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_comb begin
    sel_src  = SRC_NONE;
    sel_req  = '0;
    fifo_pop = 1'b0;
    unique case (1'b1)
      !fifo_empty: begin
        sel_src  = SRC_LSU;
        sel_req  = fifo_head;
        fifo_pop = 1'b1;
      end
      fifo_empty && lsu_valid_i: begin
        sel_src = SRC_LSU;
        sel_req = lsu_req;
      end
      fifo_empty && !lsu_valid_i && alu_valid_i: begin
        sel_src = SRC_ALU;
        sel_req = '{waddr: alu_waddr_i, wdata: alu_wdata_i};
      end
      default: ;
    endcase
  end

  assign sel_ok  = (sel_src != SRC_NONE) && in_rf(sel_req.waddr);
  assign iss_ok  = lsu_issue_i && in_rf(lsu_issue_addr_i);
  assign sel_idx = sel_req.waddr[AW-1:0];
  assign iss_idx = lsu_issue_addr_i[AW-1:0];

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_ok) set_vec[iss_idx] = 1'b1;
    if (sel_ok && sel_src == SRC_LSU) clr_vec[sel_idx] = 1'b1;
  end

  always_comb begin
    err_now = lsu_valid_i && fifo_full;
    if (sel_ok && sel_src == SRC_LSU && !pending[sel_idx]) err_now = 1'b1;
    if (sel_ok && sel_src == SRC_ALU && pending[sel_idx]) err_now = 1'b1;
    if (iss_ok && pending[iss_idx] && !clr_vec[iss_idx]) err_now = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending   <= '0;
      err_o     <= 1'b0;
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
    end else begin
      // a new issue wins over a retiring write to the same index
      pending <= (pending & ~clr_vec) | set_vec;
      err_o   <= err_o | err_now;
      we_a_o  <= sel_ok;
      if (sel_src != SRC_NONE) begin
        waddr_a_o <= sel_req.waddr;
        wdata_a_o <= sel_req.wdata;
      end
    end
  end

`ifdef IBEX_RF_WB_FWD_EN
  assign fwd_a_o    = we_a_o && waddr_a_o == raddr_a_i && raddr_a_i != 5'd0;
  assign fwd_b_o    = we_a_o && waddr_a_o == raddr_b_i && raddr_b_i != 5'd0;
  assign fwd_data_o = wdata_a_o;
`else
  assign fwd_a_o    = 1'b0;
  assign fwd_b_o    = 1'b0;
  assign fwd_data_o = '0;
`endif

  assign pend_a = in_rf(raddr_a_i) && pending[raddr_a_i[AW-1:0]];
  assign pend_b = in_rf(raddr_b_i) && pending[raddr_b_i[AW-1:0]];

  assign hazard_a_o = (raddr_a_i != 5'd0) &&
    (pend_a || (we_a_o && waddr_a_o == raddr_a_i && !fwd_a_o));
  assign hazard_b_o = (raddr_b_i != 5'd0) &&
    (pend_b || (we_a_o && waddr_a_o == raddr_b_i && !fwd_b_o));

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Bench for ibex_rf_wb_arbiter: queue/array reference model plus
// directed scenarios with literal expectations.
module tb_ibex_rf_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int NW    = 32;
`ifdef IBEX_RF_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        alu_valid;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        lsu_ready;
  logic        lsu_issue;
  logic [4:0]  lsu_issue_addr;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic        hazard_a;
  logic        hazard_b;
  logic        fwd_a;
  logic        fwd_b;
  logic [31:0] fwd_data;
  logic [4:0]  waddr_a;
  logic [31:0] wdata_a;
  logic        we_a;
  logic        err;

  always #5 clk = ~clk;

  ibex_rf_wb_arbiter #(
    .RV32E        (1'b0),
    .DataWidth    (32),
    .LsuFifoDepth (DEPTH)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .alu_valid_i      (alu_valid),
    .alu_waddr_i      (alu_waddr),
    .alu_wdata_i      (alu_wdata),
    .alu_ready_o      (alu_ready),
    .lsu_valid_i      (lsu_valid),
    .lsu_waddr_i      (lsu_waddr),
    .lsu_wdata_i      (lsu_wdata),
    .lsu_ready_o      (lsu_ready),
    .lsu_issue_i      (lsu_issue),
    .lsu_issue_addr_i (lsu_issue_addr),
    .raddr_a_i        (raddr_a),
    .raddr_b_i        (raddr_b),
    .hazard_a_o       (hazard_a),
    .hazard_b_o       (hazard_b),
    .fwd_a_o          (fwd_a),
    .fwd_b_o          (fwd_b),
    .fwd_data_o       (fwd_data),
    .waddr_a_o        (waddr_a),
    .wdata_a_o        (wdata_a),
    .we_a_o           (we_a),
    .err_o            (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  bit          pend[NW];
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit          m_err;
  ent_t        s;
  bit          has;
  bit          from_lsu;
  bit          was_full;
  bit          wr;
  bit          cmp_en = 1'b0;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      q.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      m_we  = 1'b0;
      m_wa  = '0;
      m_wd  = '0;
      m_err = 1'b0;
    end else begin
      was_full = (q.size() == DEPTH);
      has      = 1'b0;
      from_lsu = 1'b0;
      if (lsu_valid && was_full) m_err = 1'b1;
      if (q.size() > 0) begin
        s = q.pop_front();
        has = 1'b1;
        from_lsu = 1'b1;
        if (lsu_valid && !was_full) q.push_back('{lsu_waddr, lsu_wdata});
      end else if (lsu_valid) begin
        s = '{lsu_waddr, lsu_wdata};
        has = 1'b1;
        from_lsu = 1'b1;
      end else if (alu_valid) begin
        s = '{alu_waddr, alu_wdata};
        has = 1'b1;
      end
      wr = has && s.a != 5'd0;
      if (wr && from_lsu && !pend[s.a]) m_err = 1'b1;
      if (wr && !from_lsu && pend[s.a]) m_err = 1'b1;
      if (lsu_issue && lsu_issue_addr != 5'd0 && pend[lsu_issue_addr] &&
          !(wr && from_lsu && s.a == lsu_issue_addr)) m_err = 1'b1;
      if (wr && from_lsu) pend[s.a] = 1'b0;
      if (lsu_issue && lsu_issue_addr != 5'd0) pend[lsu_issue_addr] = 1'b1;
      m_we = wr;
      if (has) begin
        m_wa = s.a;
        m_wd = s.d;
      end
    end
  end

  logic e_fa, e_fb, e_ha, e_hb;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_fa = FWD && m_we && m_wa == raddr_a && raddr_a != 5'd0;
      e_fb = FWD && m_we && m_wa == raddr_b && raddr_b != 5'd0;
      e_ha = raddr_a != 5'd0 &&
             (pend[raddr_a] || (m_we && m_wa == raddr_a && !e_fa));
      e_hb = raddr_b != 5'd0 &&
             (pend[raddr_b] || (m_we && m_wa == raddr_b && !e_fb));
      chk("m_lsu_ready", 32'(lsu_ready), 32'(rst_ni && q.size() < DEPTH));
      chk("m_alu_ready", 32'(alu_ready),
          32'(rst_ni && q.size() == 0 && !lsu_valid));
      chk("m_we", 32'(we_a), 32'(m_we));
      chk("m_err", 32'(err), 32'(m_err));
      chk("m_hazard_a", 32'(hazard_a), 32'(e_ha));
      chk("m_hazard_b", 32'(hazard_b), 32'(e_hb));
      chk("m_fwd_a", 32'(fwd_a), 32'(e_fa));
      chk("m_fwd_b", 32'(fwd_b), 32'(e_fb));
      if (m_we) begin
        chk("m_waddr", 32'(waddr_a), 32'(m_wa));
        chk("m_wdata", wdata_a, m_wd);
        chk("m_fwd_data", fwd_data, FWD ? m_wd : 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    alu_valid = 0; alu_waddr = 0; alu_wdata = 0;
    lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
    lsu_issue = 0; lsu_issue_addr = 0;
    raddr_a = 0; raddr_b = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("rst_we", 32'(we_a), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_lsu_ready", 32'(lsu_ready), 0);
    chk("rst_alu_ready", 32'(alu_ready), 0);
    rst_ni = 1'b1;

    // 1: lone ALU write
    alu_valid = 1; alu_waddr = 5; alu_wdata = 32'hDEADBEEF;
    #1 chk("t1_alu_ready", 32'(alu_ready), 1);
    cyc();
    alu_valid = 0;
    #1;
    chk("t1_we", 32'(we_a), 1);
    chk("t1_waddr", 32'(waddr_a), 5);
    chk("t1_wdata", wdata_a, 32'hDEADBEEF);

    // 2: LSU beats ALU
    lsu_issue = 1; lsu_issue_addr = 7;
    cyc();
    lsu_issue = 0;
    alu_valid = 1; alu_waddr = 3; alu_wdata = 32'h33;
    lsu_valid = 1; lsu_waddr = 7; lsu_wdata = 32'h77;
    #1 chk("t2_alu_ready", 32'(alu_ready), 0);
    cyc();
    lsu_valid = 0;
    #1;
    chk("t2_waddr_lsu", 32'(waddr_a), 7);
    chk("t2_wdata_lsu", wdata_a, 32'h77);
    chk("t2_alu_ready2", 32'(alu_ready), 1);
    cyc();
    alu_valid = 0;
    #1;
    chk("t2_waddr_alu", 32'(waddr_a), 3);
    chk("t2_wdata_alu", wdata_a, 32'h33);
    chk("t2_err", 32'(err), 0);

    // 3: back-to-back LSU returns with a stalled ALU
    for (int i = 0; i < 3; i++) begin
      lsu_issue = 1; lsu_issue_addr = 5'(10 + i);
      cyc();
    end
    lsu_issue = 0;
    alu_valid = 1; alu_waddr = 13; alu_wdata = 32'hA13;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1; lsu_waddr = 5'(10 + i); lsu_wdata = 32'h100 + i;
      #1;
      chk("t3_lsu_ready", 32'(lsu_ready), 1);
      chk("t3_alu_stall", 32'(alu_ready), 0);
      cyc();
      chk("t3_waddr", 32'(waddr_a), 32'(10 + i));
    end
    lsu_valid = 0;
    #1 chk("t3_alu_ready", 32'(alu_ready), 1);
    cyc();
    alu_valid = 0;
    #1;
    chk("t3_waddr_alu", 32'(waddr_a), 13);
    chk("t3_err", 32'(err), 0);

    // 4: load-use hazard on x9
    lsu_issue = 1; lsu_issue_addr = 9; raddr_a = 9;
    cyc();
    lsu_issue = 0;
    #1 chk("t4_haz_pend", 32'(hazard_a), 1);
    cyc();
    chk("t4_haz_pend2", 32'(hazard_a), 1);
    lsu_valid = 1; lsu_waddr = 9; lsu_wdata = 32'h99;
    #1 chk("t4_haz_ret", 32'(hazard_a), 1);
    cyc();
    lsu_valid = 0;
    #1;
    chk("t4_waddr", 32'(waddr_a), 9);
    chk("t4_haz_out", 32'(hazard_a), 32'(!FWD));
    chk("t4_fwd_a", 32'(fwd_a), 32'(FWD));
    chk("t4_fwd_data", fwd_data, FWD ? 32'h99 : 32'h0);
    cyc();
    chk("t4_haz_clear", 32'(hazard_a), 0);
    raddr_a = 0;

    // 5: write to x0
    alu_valid = 1; alu_waddr = 0; alu_wdata = 32'h55; raddr_b = 0;
    #1 chk("t5_alu_ready", 32'(alu_ready), 1);
    cyc();
    alu_valid = 0;
    #1;
    chk("t5_we", 32'(we_a), 0);
    chk("t5_haz_b", 32'(hazard_b), 0);
    chk("t5_err", 32'(err), 0);

    // ALU write to a pending register
    lsu_issue = 1; lsu_issue_addr = 6;
    cyc();
    lsu_issue = 0;
    alu_valid = 1; alu_waddr = 6; alu_wdata = 32'h66;
    cyc();
    alu_valid = 0;
    #1 chk("t5b_err", 32'(err), 1);

    // 6: reset mid-operation
    lsu_issue = 1; lsu_issue_addr = 4; raddr_a = 4;
    cyc();
    lsu_issue = 0;
    #1 chk("t6_haz_pre", 32'(hazard_a), 1);
    rst_ni = 1'b0;
    #1;
    chk("t6_we", 32'(we_a), 0);
    chk("t6_err", 32'(err), 0);
    chk("t6_haz", 32'(hazard_a), 0);
    chk("t6_lsu_ready", 32'(lsu_ready), 0);
    chk("t6_alu_ready", 32'(alu_ready), 0);
    cyc();
    rst_ni = 1'b1;
    lsu_valid = 1; lsu_waddr = 4; lsu_wdata = 32'h44;
    cyc();
    lsu_valid = 0;
    #1;
    chk("t6_err_after", 32'(err), 1);
    chk("t6_waddr", 32'(waddr_a), 4);

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
